// File: rtl/dram_rd_arbiter.sv
// dram_rd_arbiter: two-requester burst-read front end for a single-port-read
// DRAM. Requester 0 is the weight loader and requester 1 is the
// pattern/feature loader. Round-robin arbitration turns each (base, len)
// request into len consecutive single-beat DRAM reads. Returned words are
// steered to the requester that owns the current burst.
//
// Ports:
//   clk, rst              clock (rising edge); asynchronous active-high reset
//   rd_req_i[1:0]         per-requester request
//   rd_base_i             start word addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_len_i              beat counts, requester i at [i*LEN_WIDTH +: LEN_WIDTH]
//   rd_ack_o[1:0]         one-cycle grant pulse to the accepted requester
//   rd_valid_o[1:0]       data-beat strobe to the owner
//   rd_last_o[1:0]        owner's final beat, or a lone pulse for len=0
//   rd_data_o             returned word, shared by both requesters
//   busy_o                high whenever the controller is not idle
//   dram_en_rd_o          DRAM read enable (registered)
//   dram_addr_rd_o        DRAM read address (registered)
//   dram_valid_i          DRAM read-data valid, one cycle after en_rd
//   dram_data_out_i       DRAM read data
module dram_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              rd_req_i,
  input  logic [2*ADDR_WIDTH-1:0] rd_base_i,
  input  logic [2*LEN_WIDTH-1:0]  rd_len_i,
  output logic [1:0]              rd_ack_o,
  output logic [1:0]              rd_valid_o,
  output logic [1:0]              rd_last_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    busy_o,
  output logic                    dram_en_rd_o,
  output logic [ADDR_WIDTH-1:0]   dram_addr_rd_o,
  input  logic                    dram_valid_i,
  input  logic [DATA_WIDTH-1:0]   dram_data_out_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ZERO} state_e;

  state_e                state_q;
  logic                  owner_q;
  logic                  last_grant_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  // Offset of the next address to issue. The grant itself issues offset 0,
  // so this counter holds 1 on entry to ISSUE.
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic [LEN_WIDTH-1:0]  ret_cnt_q;
  logic [LEN_WIDTH-1:0]  ret_cnt_d;
  logic [1:0]            ack_q;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  beat_ok;
  logic                  last_beat;
  logic                  gnt_any;
  logic                  gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [1:0]            owner_oh;

  // On a tie, the requester that did not win last time gets the grant.
  assign gnt_any  = |rd_req_i;
  assign gnt_idx  = rd_req_i[1] & (~rd_req_i[0] | ~last_grant_q);
  assign sel_base = gnt_idx ? rd_base_i[ADDR_WIDTH +: ADDR_WIDTH] : rd_base_i[0 +: ADDR_WIDTH];
  assign sel_len  = gnt_idx ? rd_len_i[LEN_WIDTH +: LEN_WIDTH]    : rd_len_i[0 +: LEN_WIDTH];

  // Return data counts only while a burst is outstanding. Stragglers that
  // arrive in IDLE or ZERO (for example after a reset) are dropped.
  assign beat_ok   = dram_valid_i & ((state_q == S_ISSUE) | (state_q == S_DRAIN));
  assign ret_cnt_d = ret_cnt_q + LEN_WIDTH'(beat_ok);
  assign last_beat = beat_ok & (ret_cnt_q == (len_q - LEN_WIDTH'(1)));
  assign owner_oh  = {owner_q, ~owner_q};

  assign rd_data_o      = dram_data_out_i;
  assign rd_valid_o     = {2{beat_ok}} & owner_oh;
  assign rd_last_o      = {2{last_beat | (state_q == S_ZERO)}} & owner_oh;
  assign rd_ack_o       = ack_q;
  assign busy_o         = (state_q != S_IDLE);
  assign dram_en_rd_o   = en_q;
  assign dram_addr_rd_o = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      base_q       <= '0;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      ack_q        <= '0;
      en_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      ack_q     <= '0;
      ret_cnt_q <= ret_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            owner_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            base_q       <= sel_base;
            len_q        <= sel_len;
            ack_q        <= gnt_idx ? 2'b10 : 2'b01;
            issue_cnt_q  <= LEN_WIDTH'(1);
            ret_cnt_q    <= '0;
            if (sel_len == '0) begin
              state_q <= S_ZERO;
            end else begin
              // The first read is issued in the same cycle as the ack.
              state_q <= S_ISSUE;
              en_q    <= 1'b1;
              addr_q  <= sel_base;
            end
          end
        end
        S_ISSUE: begin
          if (issue_cnt_q == len_q) begin
            en_q    <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q      <= base_q + ADDR_WIDTH'(issue_cnt_q);
            issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          // Leave on the edge that accepts the final beat.
          if (ret_cnt_d == len_q) state_q <= S_IDLE;
        end
        S_ZERO: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Directed bench for dram_rd_arbiter. The bench includes a one-cycle-latency
// DRAM model whose word at address a is a. It checks the cycle-by-cycle
// outputs of each burst.
module tb_dram_rd_arbiter;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      rd_req;
  logic [2*AW-1:0] rd_base;
  logic [2*LW-1:0] rd_len;
  logic [1:0]      rd_ack, rd_valid, rd_last;
  logic [DW-1:0]   rd_data;
  logic            busy, dram_en_rd, dram_valid;
  logic [AW-1:0]   dram_addr_rd;
  logic [DW-1:0]   dram_data_out;

  logic            dv_q = 1'b0;
  logic [DW-1:0]   dd_q = '0;
  logic            inj_valid;
  int              cyc = 0;
  int              ack0_cyc = 0, ack1_cyc = 0;
  int              n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req), .rd_base_i(rd_base), .rd_len_i(rd_len),
    .rd_ack_o(rd_ack), .rd_valid_o(rd_valid), .rd_last_o(rd_last),
    .rd_data_o(rd_data), .busy_o(busy),
    .dram_en_rd_o(dram_en_rd), .dram_addr_rd_o(dram_addr_rd),
    .dram_valid_i(dram_valid), .dram_data_out_i(dram_data_out)
  );

  // DRAM model: data[a] = a, valid one cycle after en_rd.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    dv_q <= dram_en_rd;
    dd_q <= DW'(dram_addr_rd);
  end
  assign dram_valid    = dv_q | inj_valid;
  assign dram_data_out = dd_q;

  always @(negedge clk) begin
    if (rd_ack[0]) ack0_cyc = cyc;
    if (rd_ack[1]) ack1_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request on requester idx, then check every cycle from the ack to the
  // first idle cycle after the burst.
  task automatic burst(input int idx, input logic [AW-1:0] base, input logic [LW-1:0] len,
                       input string tag);
    logic [1:0] oh;
    logic [AW-1:0] a;
    oh = 2'b01 << idx;
    rd_req[idx] = 1'b1;
    rd_base[idx*AW +: AW] = base;
    rd_len[idx*LW +: LW] = len;
    for (int i = 0; i <= int'(len) + 1; i++) begin
      @(negedge clk);
      chk({tag, "_ack"}, rd_ack, (i == 0) ? oh : 2'b00);
      chk({tag, "_en"}, dram_en_rd, i < int'(len));
      if (i < int'(len)) begin
        a = AW'(int'(base) + i);
        chk({tag, "_addr"}, dram_addr_rd, a);
      end
      chk({tag, "_valid"}, rd_valid, (i >= 1 && i <= int'(len)) ? oh : 2'b00);
      if (i >= 1 && i <= int'(len)) begin
        a = AW'(int'(base) + i - 1);
        chk({tag, "_data"}, rd_data, DW'(a));
      end
      chk({tag, "_last"}, rd_last, (i == int'(len)) ? oh : 2'b00);
      chk({tag, "_busy"}, busy, i <= int'(len));
      if (i == 0) rd_req[idx] = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_req = '0; rd_base = '0; rd_len = '0; inj_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", dram_en_rd, 1'b0);
    chk("rst_addr", dram_addr_rd, '0);
    chk("rst_ack", rd_ack, 2'b00);
    chk("rst_last", rd_last, 2'b00);
    rst = 1'b0;

    // Single requester, len=4.
    burst(0, 18'h00100, 8'd4, "r0_len4");

    // Tie after reset: 0 first, then 1, then 0 again, which has lost to 1.
    pulse_rst();
    rd_req[1] = 1'b1; rd_base[AW +: AW] = 18'h00300; rd_len[LW +: LW] = 8'd2;
    burst(0, 18'h00200, 8'd2, "tie_r0");
    rd_req[0] = 1'b1; rd_base[0 +: AW] = 18'h00210; rd_len[0 +: LW] = 8'd2;
    burst(1, 18'h00300, 8'd2, "tie_r1");
    burst(0, 18'h00210, 8'd2, "tie_r0b");

    // Zero-length request.
    burst(1, 18'h00050, 8'd0, "r1_len0");

    // Address wrap.
    burst(0, 18'h3FFFE, 8'd4, "wrap");

    // Reset during the third issue of an 8-beat burst.
    rd_req[0] = 1'b1; rd_base[0 +: AW] = 18'h00400; rd_len[0 +: LW] = 8'd8;
    @(negedge clk);
    rd_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_en3", dram_en_rd, 1'b1);
    chk("mid_addr3", dram_addr_rd, 18'h00402);
    rst = 1'b1;
    #1;
    chk("mid_en_drop", dram_en_rd, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_valid", rd_valid, 2'b00);
    chk("mid_last", rd_last, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    inj_valid = 1'b1;
    #1;
    chk("late_valid", rd_valid, 2'b00);
    chk("late_last", rd_last, 2'b00);
    @(negedge clk);
    inj_valid = 1'b0;
    chk("late_busy", busy, 1'b0);
    burst(0, 18'h00500, 8'd8, "post_rst");

    // Make last_grant = 1 so requester 0 wins the next tie.
    burst(1, 18'h00000, 8'd0, "prep");
    // Back-to-back: requester 1 waits through a 255-beat burst.
    rd_req[1] = 1'b1; rd_base[AW +: AW] = 18'h00600; rd_len[LW +: LW] = 8'd3;
    burst(0, 18'h01000, 8'd255, "long");
    burst(1, 18'h00600, 8'd3, "after_long");
    chk("b2b_gap", 64'(ack1_cyc - ack0_cyc), 64'd257);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
